// File: rtl/pwm_pkg.sv
// Shared definitions for the push-button PWM duty controller.
package pwm_pkg;

    localparam int PWM_W   = 7;
    localparam int PWM_MAX = 99;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } state_t;

    // Saturating duty step. Computed 8 bits wide so the up path cannot
    // overflow, and the down path compares before subtracting so it never wraps.
    function automatic logic [PWM_W-1:0] sat_step(
        input logic [PWM_W-1:0] cur,
        input logic             up,
        input logic [7:0]       step
    );
        logic [7:0]       wide;
        logic [PWM_W-1:0] res;
        wide = {1'b0, cur};
        if (up) begin
            wide = wide + step;
            if (wide > 8'(PWM_MAX)) begin
                res = PWM_W'(PWM_MAX);
            end else begin
                res = wide[PWM_W-1:0];
            end
        end else begin
            if (wide < step) begin
                res = {PWM_W{1'b0}};
            end else begin
                wide = wide - step;
                res  = wide[PWM_W-1:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/pwm_duty_controller_debounce_sync.sv
// Two-flop synchronizer followed by a stable-level debounce counter.
module debounce_sync #(
    parameter int DB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic ena,
    input  logic din,
    output logic dout
);

    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

    logic          r_sync1;
    logic          r_sync2;
    logic          r_db;
    logic [CW-1:0] r_cnt;

    // Synchronizer runs every clock, independent of the enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= din;
            r_sync2 <= r_sync1;
        end
    end

    // Count consecutive enabled cycles of disagreement; flip the clean level once stable long enough.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_db  <= 1'b0;
            r_cnt <= {CW{1'b0}};
        end else if (ena) begin
            if (r_sync2 == r_db) begin
                r_cnt <= {CW{1'b0}};
            end else if (r_cnt == CW'(DB_CYCLES - 1)) begin
                r_db  <= r_sync2;
                r_cnt <= {CW{1'b0}};
            end else begin
                r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
            end
        end
    end

    assign dout = r_db;

endmodule

// File: rtl/pwm_duty_controller.sv
// Button-driven duty controller: debounce, key FSM with auto-repeat,
// saturating target, and a period-aligned Npwm shadow register.
module pwm_duty_controller
    import pwm_pkg::*;
#(
    parameter int DB_CYCLES    = 16,
    parameter int REPEAT_DELAY = 64,
    parameter int REPEAT_RATE  = 16,
    parameter int STEP         = 1,
    parameter int INIT_DUTY    = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             xu,
    input  logic             xd,
    input  logic             pstart,
    output logic [PWM_W-1:0] Npwm,
    output logic             at_max,
    output logic             at_min
);

    localparam int          RC_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int          RC_W   = $clog2(RC_MAX) + 1;
    localparam logic [7:0]  STEP_W = 8'(STEP);

    logic             w_db_up;
    logic             w_db_dn;
    logic             w_key_up;
    logic             w_key_dn;
    logic             w_release;
    logic             w_step;
    logic             w_dir_nxt;
    logic [RC_W-1:0]  w_rc_nxt;
    state_t           w_state_nxt;
    logic [PWM_W-1:0] w_target_step;

    state_t           r_state;
    logic [RC_W-1:0]  r_rc;
    logic             r_dir;
    logic [PWM_W-1:0] r_target;
    logic [PWM_W-1:0] r_npwm;

    debounce_sync #(.DB_CYCLES(DB_CYCLES)) u_db_up (
        .clk (clk),
        .rst (rst),
        .ena (ena),
        .din (xu),
        .dout(w_db_up)
    );

    debounce_sync #(.DB_CYCLES(DB_CYCLES)) u_db_dn (
        .clk (clk),
        .rst (rst),
        .ena (ena),
        .din (xd),
        .dout(w_db_dn)
    );

    // Both buttons down decodes as no key.
    assign w_key_up  = w_db_up & ~w_db_dn;
    assign w_key_dn  = w_db_dn & ~w_db_up;
    // Leaving the latched direction (to none or the opposite key) ends the hold.
    assign w_release = r_dir ? ~w_key_up : ~w_key_dn;

    // Next-state, repeat counter and step-request decode.
    always_comb begin
        w_state_nxt = r_state;
        w_rc_nxt    = r_rc;
        w_dir_nxt   = r_dir;
        w_step      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_key_up || w_key_dn) begin
                    w_state_nxt = HOLD;
                    w_rc_nxt    = {RC_W{1'b0}};
                    w_dir_nxt   = w_key_up;
                    w_step      = 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            HOLD: begin
                if (w_release) begin
                    w_state_nxt = IDLE;
                    w_rc_nxt    = {RC_W{1'b0}};
                end else if (r_rc == RC_W'(REPEAT_DELAY - 1)) begin
                    w_state_nxt = REPEAT;
                    w_rc_nxt    = {RC_W{1'b0}};
                    w_step      = 1'b1;
                end else begin
                    w_rc_nxt    = r_rc + {{(RC_W-1){1'b0}}, 1'b1};
                end
            end
            REPEAT: begin
                if (w_release) begin
                    w_state_nxt = IDLE;
                    w_rc_nxt    = {RC_W{1'b0}};
                end else if (r_rc == RC_W'(REPEAT_RATE - 1)) begin
                    w_rc_nxt    = {RC_W{1'b0}};
                    w_step      = 1'b1;
                end else begin
                    w_rc_nxt    = r_rc + {{(RC_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_rc_nxt    = {RC_W{1'b0}};
            end
        endcase
    end

    assign w_target_step = sat_step(r_target, w_dir_nxt, STEP_W);

    // FSM, target and shadow register; Npwm samples the pre-step target on pstart.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_rc     <= {RC_W{1'b0}};
            r_dir    <= 1'b0;
            r_target <= PWM_W'(INIT_DUTY);
            r_npwm   <= PWM_W'(INIT_DUTY);
        end else if (ena) begin
            r_state <= w_state_nxt;
            r_rc    <= w_rc_nxt;
            r_dir   <= w_dir_nxt;
            if (w_step) begin
                r_target <= w_target_step;
            end
            if (pstart) begin
                r_npwm <= r_target;
            end
        end
    end

    assign Npwm   = r_npwm;
    assign at_max = (r_target == PWM_W'(PWM_MAX));
    assign at_min = (r_target == {PWM_W{1'b0}});

endmodule

// File: tb/tb_pwm_duty_controller.sv
// Directed bench for pwm_duty_controller (DB=4, DELAY=8, RATE=3).
module tb_pwm_duty_controller;
    import pwm_pkg::*;

    logic       clk = 1'b0;
    logic       rst, ena, pstart;
    logic       xu, xd, xu_b, xd_b, xu_c, xd_c;
    logic [6:0] npwm, npwm_b, npwm_c;
    logic       at_max, at_min, at_max_b, at_min_b, at_max_c, at_min_c;

    int n_pass   = 0;
    int n_checks = 0;

    always #5 clk = ~clk;

    pwm_duty_controller #(.DB_CYCLES(4), .REPEAT_DELAY(8), .REPEAT_RATE(3), .STEP(1), .INIT_DUTY(0)) dut (
        .clk(clk), .rst(rst), .ena(ena), .xu(xu), .xd(xd), .pstart(pstart),
        .Npwm(npwm), .at_max(at_max), .at_min(at_min));

    pwm_duty_controller #(.DB_CYCLES(4), .REPEAT_DELAY(8), .REPEAT_RATE(3), .STEP(5), .INIT_DUTY(98)) dut_b (
        .clk(clk), .rst(rst), .ena(ena), .xu(xu_b), .xd(xd_b), .pstart(pstart),
        .Npwm(npwm_b), .at_max(at_max_b), .at_min(at_min_b));

    pwm_duty_controller #(.DB_CYCLES(4), .REPEAT_DELAY(8), .REPEAT_RATE(3), .STEP(5), .INIT_DUTY(3)) dut_c (
        .clk(clk), .rst(rst), .ena(ena), .xu(xu_c), .xd(xd_c), .pstart(pstart),
        .Npwm(npwm_c), .at_max(at_max_c), .at_min(at_min_c));

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    initial begin
        rst = 1'b1; ena = 1'b1; pstart = 1'b0;
        xu = 1'b0; xd = 1'b0; xu_b = 1'b0; xd_b = 1'b0; xu_c = 1'b0; xd_c = 1'b0;
        tick(2);
        check("rst_npwm",   32'(npwm), 32'd0);
        check("rst_at_min", 32'(at_min), 32'd1);
        check("rst_at_max", 32'(at_max), 32'd0);
        check("rst_state",  32'(dut.r_state), 32'(IDLE));
        check("rst_npwm_b", 32'(npwm_b), 32'd98);
        check("rst_flags_b", 32'({at_max_b, at_min_b}), 32'd0);
        check("rst_npwm_c", 32'(npwm_c), 32'd3);
        check("rst_flags_c", 32'({at_max_c, at_min_c}), 32'd0);
        rst = 1'b0;

        // Single 10-cycle press: first step at edge 6, second HOLD step lands at edge 14
        xu = 1'b1;
        tick(6);
        check("press_pre",  32'(dut.r_target), 32'd0);
        tick(1);
        check("press_step", 32'(dut.r_target), 32'd1);
        check("press_npwm_hold", 32'(npwm), 32'd0);
        pstart = 1'b1; tick(1); pstart = 1'b0;
        check("press_npwm_apply", 32'(npwm), 32'd1);
        tick(2);
        xu = 1'b0;
        tick(10);
        check("pulse_final", 32'(dut.r_target), 32'd2);
        check("pulse_idle",  32'(dut.r_state), 32'(IDLE));
        check("pulse_npwm_frozen", 32'(npwm), 32'd1);
        pstart = 1'b1; tick(1); pstart = 1'b0;
        check("pulse_npwm_apply", 32'(npwm), 32'd2);

        // Bouncing glitch, never stable for 4 enabled cycles
        xu = 1'b1; tick(1); xu = 1'b0; tick(1);
        xu = 1'b1; tick(3); xu = 1'b0;
        tick(10);
        check("glitch_target", 32'(dut.r_target), 32'd2);
        check("glitch_idle",   32'(dut.r_state), 32'(IDLE));

        // 40-cycle hold from 0: steps at 6,14,17,...,44 -> 12 steps
        rst = 1'b1; tick(1); rst = 1'b0;
        check("rerst_target", 32'(dut.r_target), 32'd0);
        xu = 1'b1;
        tick(14);
        check("hold_e13", 32'(dut.r_target), 32'd1);
        tick(1);
        check("hold_e14", 32'(dut.r_target), 32'd2);
        check("hold_repeat_state", 32'(dut.r_state), 32'(REPEAT));
        tick(2);
        check("hold_e16", 32'(dut.r_target), 32'd2);
        tick(1);
        check("hold_e17", 32'(dut.r_target), 32'd3);
        tick(22);
        xu = 1'b0;
        tick(10);
        check("hold_final", 32'(dut.r_target), 32'd12);
        check("hold_idle",  32'(dut.r_state), 32'(IDLE));
        check("hold_npwm",  32'(npwm), 32'd0);

        // Saturation with STEP=5
        xu_b = 1'b1; tick(7); xu_b = 1'b0;
        check("sat_up",     32'(dut_b.r_target), 32'd99);
        check("sat_at_max", 32'(at_max_b), 32'd1);
        tick(10);
        xu_b = 1'b1; tick(7); xu_b = 1'b0;
        check("sat_up_again", 32'(dut_b.r_target), 32'd99);
        check("sat_at_max2",  32'(at_max_b), 32'd1);
        tick(10);
        xd_c = 1'b1; tick(7); xd_c = 1'b0;
        check("sat_dn",     32'(dut_c.r_target), 32'd0);
        check("sat_at_min", 32'(at_min_c), 32'd1);
        tick(10);

        // Both held -> NONE; releasing xd exposes UP
        xu = 1'b1; xd = 1'b1;
        tick(15);
        check("both_no_step", 32'(dut.r_target), 32'd12);
        check("both_idle",    32'(dut.r_state), 32'(IDLE));
        xd = 1'b0;
        tick(6);
        check("both_rel_pre", 32'(dut.r_target), 32'd12);
        tick(1);
        check("both_rel_step", 32'(dut.r_target), 32'd13);
        xu = 1'b0;
        tick(10);
        check("both_rel_final", 32'(dut.r_target), 32'd13);

        // Step on the same edge as pstart: Npwm takes pre-step target
        xu = 1'b1;
        tick(6);
        pstart = 1'b1; tick(1); pstart = 1'b0;
        xu = 1'b0;
        check("coinc_npwm",   32'(npwm), 32'd13);
        check("coinc_target", 32'(dut.r_target), 32'd14);
        tick(10);
        ena = 1'b0; pstart = 1'b1; tick(1); pstart = 1'b0; ena = 1'b1;
        check("ena_low_pstart", 32'(npwm), 32'd13);
        tick(2);
        pstart = 1'b1; tick(1); pstart = 1'b0;
        check("next_pstart", 32'(npwm), 32'd14);

        // Reset in the middle of REPEAT: 14 -> 15@6, 16@14, 17@17
        xu = 1'b1;
        tick(20);
        check("mid_repeat_state",  32'(dut.r_state), 32'(REPEAT));
        check("mid_repeat_target", 32'(dut.r_target), 32'd17);
        rst = 1'b1; tick(1); rst = 1'b0; xu = 1'b0;
        check("rst_rep_state",  32'(dut.r_state), 32'(IDLE));
        check("rst_rep_npwm",   32'(npwm), 32'd0);
        check("rst_rep_target", 32'(dut.r_target), 32'd0);
        tick(5);
        check("post_rst_quiet", 32'(dut.r_target), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
